// File: rtl/d8_mem_data_clr.sv
// Parametrised single-port data RAM for the dumb8 core with a hardware clear
// sweep after reset or on request, and a selectable combinational/registered read.
module d8_mem_data_clr #(
    parameter int            DW      = 8,
    parameter int            AW      = 8,
    parameter int            DEPTH   = 256,
    parameter int            REG_OUT = 0,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          w,
    input  logic          clr,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          done
);

    // Handshake: busy is high from reset (or the edge that accepts clr) until
    // the sweep's final write; while busy, w and clr are ignored and dout reads
    // CLR_VAL. done is a single-cycle pulse in the first cycle busy is low.

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   LAST    = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE     = (AW+1)'(1);

    localparam logic [0:0]    CLEAR   = 1'b0;
    localparam logic [0:0]    IDLE    = 1'b1;

    logic [0:0]    state;
    logic [AW:0]   cnt;
    logic          done_q;
    logic [DW-1:0] mem [0:DEPTH-1];

    logic          in_range;
    logic [IW-1:0] addr_idx;
    logic [IW-1:0] cnt_idx;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] view;
    logic          user_wr;

    // Addresses at or above DEPTH never alias onto real words.
    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign addr_idx = addr[IW-1:0];
    assign cnt_idx  = cnt[IW-1:0];
    assign rd_word  = in_range ? mem[addr_idx] : CLR_VAL;
    assign view     = w ? din : rd_word;
    assign user_wr  = (state == IDLE) && !clr && w && in_range;

    assign busy = (state == CLEAR);
    assign done = done_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                CLEAR: begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // The array has no reset; the sweep rewrites every word instead.
    always_ff @(posedge sys_clk) begin
        if (state == CLEAR) begin
            mem[cnt_idx] <= CLR_VAL;
        end else if (user_wr) begin
            mem[addr_idx] <= din;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [DW-1:0] dout_q;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    dout_q <= CLR_VAL;
                end else if (state == CLEAR) begin
                    dout_q <= CLR_VAL;
                end else begin
                    dout_q <= view;
                end
            end

            assign dout = busy ? CLR_VAL : dout_q;
        end else begin : g_comb_out
            assign dout = busy ? CLR_VAL : view;
        end
    endgenerate

endmodule
